// File: rtl/ofdm_spi_pkg.sv
// Shared constants and FSM state type for the OFDM SPI register slave.
package ofdm_spi_pkg;
  localparam int         SPI_FRAME_BITS = 16;
  localparam int         CMD_RW_BIT     = 7;
  localparam int         CMD_SPACE_BIT  = 6;
  localparam logic [5:0] STAT_BASE      = 6'h00;
  localparam logic [3:0] CMD_LAST_BIT   = 4'(SPI_FRAME_BITS / 2 - 1);
  localparam logic [3:0] FRAME_LAST_BIT = 4'(SPI_FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} spi_state_e;
endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with edge detection.
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Resets to 0 so a chip select held low through reset never looks like a fresh fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;
endmodule

// File: rtl/ofdm_spi_slave_regs.sv
// SPI mode-0 slave with a byte-wide register file and read-only status bytes.
//  state | meaning
//  IDLE  | waiting for chip-select fall
//  CMD   | shifting in the command byte
//  DATA  | shifting write data in / read data out
//  DONE  | frame complete, waiting for chip-select rise
module ofdm_spi_slave_regs
  import ofdm_spi_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int NUM_STAT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_sclk,
  input  logic                  spi_nss,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [8*NUM_STAT-1:0] stat_in,
  output logic [8*NUM_REGS-1:0] reg_out,
  output logic                  wr_strobe,
  output logic [5:0]            wr_addr
);
  spi_state_e state, state_nxt;
  logic       sclk_rise, sclk_fall, nss_rise, nss_fall, mosi_s;
  logic       unused_sclk_lvl, unused_nss_lvl, unused_mosi_rise, unused_mosi_fall;
  logic [3:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte, cmd, tx_shift, rd_byte, tx_load;
  logic [7:0] regs [NUM_REGS];
  logic       commit_pend, wr_ok;
  logic [5:0] commit_addr;
  logic [7:0] commit_data;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .din(spi_sclk),
    .dout(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_nss (
    .clk(clk), .reset_n(reset_n), .din(spi_nss),
    .dout(unused_nss_lvl), .rise(nss_rise), .fall(nss_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .din(spi_mosi),
    .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

  assign rx_byte = {rx_shift, mosi_s};
  assign wr_ok   = !cmd[CMD_SPACE_BIT] && (int'(cmd[5:0]) < NUM_REGS);

  // Read byte is chosen from the command as it completes, so stat_in is sampled here.
  always_comb begin
    rd_byte = 8'h00;
    if (!rx_byte[CMD_SPACE_BIT]) begin
      for (int k = 0; k < NUM_REGS; k++)
        if (rx_byte[5:0] == 6'(k)) rd_byte = regs[k];
    end else begin
      for (int k = 0; k < NUM_STAT; k++)
        if (rx_byte[5:0] == STAT_BASE + 6'(k)) rd_byte = stat_in[8*k +: 8];
    end
    tx_load = rx_byte[CMD_RW_BIT] ? rd_byte : 8'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (nss_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (nss_fall) state_nxt = CMD;
        CMD:     if (sclk_rise && bit_cnt == CMD_LAST_BIT) state_nxt = DATA;
        DATA:    if (sclk_rise && bit_cnt == FRAME_LAST_BIT) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      cmd         <= '0;
      tx_shift    <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      commit_pend <= 1'b0;
      commit_addr <= '0;
      commit_data <= '0;
    end else begin
      wr_strobe   <= 1'b0;
      commit_pend <= 1'b0;
      if (commit_pend) begin
        for (int k = 0; k < NUM_REGS; k++)
          if (commit_addr == 6'(k)) regs[k] <= commit_data;
        wr_strobe <= 1'b1;
        wr_addr   <= commit_addr;
      end
      if (nss_fall)      spi_miso_oe <= 1'b1;
      else if (nss_rise) spi_miso_oe <= 1'b0;

      if (nss_rise) begin
        bit_cnt  <= '0;
        spi_miso <= 1'b0;
      end else begin
        case (state)
          IDLE: if (nss_fall) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            spi_miso <= 1'b0;
          end
          CMD: if (sclk_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == CMD_LAST_BIT) begin
              cmd      <= rx_byte;
              tx_shift <= tx_load;
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == FRAME_LAST_BIT && !cmd[CMD_RW_BIT] && wr_ok) begin
                commit_pend <= 1'b1;
                commit_addr <= cmd[5:0];
                commit_data <= rx_byte;
              end
            end
            if (sclk_fall) begin
              spi_miso <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign reg_out[8*k +: 8] = regs[k];
  end
endmodule

// File: tb/tb_ofdm_spi_slave_regs.sv
// Scoreboard bench: SPI master stimulus pushes expectations, pin/strobe monitors pop and compare.
module tb_ofdm_spi_slave_regs;
  localparam int NR = 8;
  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            spi_sclk = 1'b0;
  logic            spi_nss = 1'b1;
  logic            spi_mosi = 1'b0;
  logic            spi_miso, spi_miso_oe, wr_strobe;
  logic [5:0]      wr_addr;
  logic [8*NS-1:0] stat_in = '0;
  logic [8*NR-1:0] reg_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [5:0]      addr;
    logic [8*NR-1:0] image;
  } wr_exp_t;

  wr_exp_t     exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  m_regs [NR];
  wr_exp_t     mon_e;
  int          mon_bits = 0;
  logic [15:0] mon_word = '0;
  bit          mon_live = 1'b0;

  ofdm_spi_slave_regs #(.NUM_REGS(NR), .NUM_STAT(NS), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .spi_sclk(spi_sclk), .spi_nss(spi_nss),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .stat_in(stat_in), .reg_out(reg_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr));

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8*NR-1:0] model_image();
    logic [8*NR-1:0] v;
    for (int k = 0; k < NR; k++) v[8*k +: 8] = m_regs[k];
    return v;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] c);
    int a;
    a = int'(c[5:0]);
    if (!c[7]) return 8'h00;
    if (!c[6] && a < NR) return m_regs[a];
    if (c[6] && a < NS) return stat_in[8*a +: 8];
    return 8'h00;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic v, input int half);
    spi_mosi = v;
    wait_clk(half);
    spi_sclk = 1'b1;
    wait_clk(half);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_end(input int half, input int gap);
    wait_clk(half);
    spi_nss = 1'b1;
    wait_clk(gap);
  endtask

  task automatic do_frame(input logic [7:0] c, input logic [7:0] d, input int half, input int gap);
    wr_exp_t     e;
    logic [15:0] w;
    w = {c, d};
    exp_rd.push_back({8'h00, model_read(c)});
    if (!c[7] && !c[6] && int'(c[5:0]) < NR) begin
      m_regs[int'(c[5:0])] = d;
      e.addr  = c[5:0];
      e.image = model_image();
      exp_wr.push_back(e);
    end
    spi_nss = 1'b0;
    for (int i = 15; i >= 0; i--) spi_bit(w[i], half);
    spi_end(half, gap);
    check("reg_out_after_frame", 64'(reg_out), 64'(model_image()));
  endtask

  // Pin-level monitor: captures MISO as the master would, on each SCLK rise.
  always @(negedge spi_nss) begin
    mon_bits = 0;
    mon_word = '0;
    mon_live = reset_n;
  end

  always @(negedge reset_n) mon_live = 1'b0;

  always @(posedge spi_sclk) begin
    if (!spi_nss && mon_live) begin
      mon_word = {mon_word[14:0], spi_miso};
      mon_bits++;
      check("miso_oe_in_frame", 64'(spi_miso_oe), 64'd1);
    end
  end

  always @(posedge spi_nss) begin
    if (mon_live && mon_bits == 16) begin
      mon_live = 1'b0;
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL miso_frame_unexpected: got %0h, expected no frame", mon_word);
      end else begin
        check("miso_word", 64'(mon_word), 64'(exp_rd.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && wr_strobe) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_strobe_unexpected: got strobe addr %0d, expected none", wr_addr);
      end else begin
        mon_e = exp_wr.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
        check("reg_image_at_strobe", 64'(reg_out), 64'(mon_e.image));
      end
    end
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [7:0]  c;
    for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;

    wait_clk(3);
    check("rst_reg_out", 64'(reg_out), 64'd0);
    check("rst_miso", 64'(spi_miso), 64'd0);
    check("rst_miso_oe", 64'(spi_miso_oe), 64'd0);
    check("rst_wr_strobe", 64'(wr_strobe), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    reset_n = 1'b1;
    wait_clk(5);

    do_frame(8'h03, 8'hA5, 4, 4);
    do_frame(8'h83, 8'h00, 4, 6);
    check("miso_oe_after_frame", 64'(spi_miso_oe), 64'd0);

    stat_in = 32'h11_22_5C_33;
    do_frame(8'hC1, 8'h00, 5, 4);
    do_frame(8'hC7, 8'h00, 5, 4);
    do_frame(8'h8A, 8'h00, 5, 4);

    do_frame(8'h0A, 8'hFF, 4, 4);
    do_frame(8'h42, 8'h11, 4, 4);

    w = 16'h0277;
    spi_nss = 1'b0;
    for (int i = 15; i >= 4; i--) spi_bit(w[i], 4);
    spi_end(4, 6);
    check("reg_out_after_abort12", 64'(reg_out), 64'(model_image()));
    do_frame(8'h02, 8'h66, 4, 4);

    // Chip-select rise in the same clock as the 16th SCLK rise aborts the write.
    w = 16'h043C;
    spi_nss = 1'b0;
    for (int i = 15; i >= 1; i--) spi_bit(w[i], 4);
    spi_mosi = w[0];
    wait_clk(4);
    spi_nss  = 1'b1;
    spi_sclk = 1'b1;
    wait_clk(4);
    spi_sclk = 1'b0;
    wait_clk(6);
    check("reg_out_after_abort16", 64'(reg_out), 64'(model_image()));

    w = 16'h0199;
    spi_nss = 1'b0;
    for (int i = 15; i >= 6; i--) spi_bit(w[i], 4);
    reset_n = 1'b0;
    wait_clk(2);
    for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
    check("midrst_reg_out", 64'(reg_out), 64'd0);
    check("midrst_miso", 64'(spi_miso), 64'd0);
    check("midrst_miso_oe", 64'(spi_miso_oe), 64'd0);
    check("midrst_wr_strobe", 64'(wr_strobe), 64'd0);
    check("midrst_wr_addr", 64'(wr_addr), 64'd0);
    reset_n = 1'b1;
    for (int i = 5; i >= 0; i--) spi_bit(w[i], 4);
    check("miso_oe_ignored_frame", 64'(spi_miso_oe), 64'd0);
    spi_end(4, 4);
    check("reg_out_after_midrst", 64'(reg_out), 64'd0);

    for (int k = 0; k < NR; k++) do_frame(8'(k), 8'($urandom), 4, 2);
    for (int k = 0; k < NR; k++) do_frame(8'h80 | 8'(k), 8'($urandom), 4, 2);

    for (int n = 0; n < 40; n++) begin
      stat_in = 32'($urandom);
      c = {1'($urandom), 1'($urandom), 6'($urandom_range(0, 11))};
      do_frame(c, 8'($urandom), int'($urandom_range(4, 7)), int'($urandom_range(2, 5)));
    end

    wait_clk(10);
    check("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
    check("exp_rd_drained", 64'(exp_rd.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
